// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between N valid/ready
// requesters. A round-robin arbiter picks a lane, its operands are latched,
// executed on the single alu instance, and the result is returned on an
// id-tagged valid/ready response channel. One operation per three cycles.

// Combinational ALU: add/sub/and/or/xor; results wrap modulo 2^WIDTH.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Operation select; undefined codes produce zero.
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y = '0;
        case (op)
            3'b000:  y = a + b;
            3'b001:  y = a - b;
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b100:  y = a ^ b;
            default: y = '0;
        endcase
    end

`ifndef SYNTHESIS
    // Catch any caller that lets an undefined op code reach the datapath.
    always_comb begin
        assert (op <= 3'b100) else $error("alu: undefined op code %0d", op);
    end
`endif

endmodule

module alu_rr_scheduler #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    input  logic [N*3-1:0]     req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [WIDTH-1:0]   rsp_y,
    output logic               rsp_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MAX = 3'b100;

    state_t           state_q,   state_d;
    logic [IDW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [IDW-1:0]   id_q,      id_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [2:0]       op_q,      op_d;
    logic [IDW-1:0]   rsp_id_q,  rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q,   rsp_y_d;
    logic             rsp_err_q, rsp_err_d;

    logic             any_valid;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   grant_next;
    logic [N-1:0]     grant_oh;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    logic             op_invalid;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_y;

    // Round-robin search: first valid lane at or after rr_ptr, wrapping.
    always_comb begin
        logic [IDW:0] cand;
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!any_valid && req_valid[cand[IDW-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
    end

    // Pointer moves to the lane after the winner so it gets lowest priority.
    always_comb begin
        grant_next = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // Decode the winner to a one-hot and mux its operands.
    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_op   = '0;
        for (int i = 0; i < N; i++) begin
            if (any_valid && grant_idx == IDW'(i)) begin
                grant_oh[i] = 1'b1;
                sel_a       = req_a[i*WIDTH +: WIDTH];
                sel_b       = req_b[i*WIDTH +: WIDTH];
                sel_op      = req_op[i*3 +: 3];
            end
        end
    end

    // Undefined op codes are steered to a harmless add; the result is zeroed later.
    always_comb begin
        op_invalid = (op_q > OP_MAX);
        alu_op     = op_invalid ? 3'b000 : op_q;
    end

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op(alu_op),
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );

    // Next-state and handshake logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rsp_id_d  = rsp_id_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    // Nothing is accepted while reset is held.
                    req_ready = rst_n ? grant_oh : '0;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    op_d      = sel_op;
                    id_d      = grant_idx;
                    rr_ptr_d  = grant_next;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d   = op_invalid ? '0 : alu_y;
                rsp_err_d = op_invalid;
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, latched request and response registers.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values and the update order within the block is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_id_q  <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rsp_id_q  <= rsp_id_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Response channel and status are pure functions of registered state.
    always_comb begin
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
        rsp_id    = rsp_id_q;
        rsp_y     = rsp_y_q;
        rsp_err   = rsp_err_q;
    end

`ifndef SYNTHESIS
    // At most one requester is accepted in any cycle.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready))
        else $error("alu_rr_scheduler: more than one req_ready high");

    // A stalled response must keep its payload until it is taken.
    assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_id) && $stable(rsp_y) && $stable(rsp_err)))
        else $error("alu_rr_scheduler: response changed while stalled");
`endif

endmodule
